multi_4bit: RTL and testbench

MULTI_4BIT -- requirements
Module: multi_4bit

---
 rtl/multi_4bit.sv | 100 ++++++++++
 tb/tb_multi_4bit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/multi_4bit.sv
// Registered 4x4 unsigned array multiplier: input register, AND/ripple-adder array, output register.
// Define MULTI_4BIT_PIPE_EN to add a register stage after the second adder row (latency 2 instead of 1).
module multi_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       in_valid,
  output logic [7:0] P,
  output logic       out_valid
);

  // One adder row: 4 full adders with rippled carry, carry-out in bit 4.
  function automatic logic [4:0] row_add(input logic [3:0] x, input logic [3:0] y);
    logic       c;
    logic [4:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[4] = c;
    return r;
  endfunction

  logic [3:0] a_q, b_q;
  logic       v_q;
  logic [3:0] pp0, pp1, pp2, pp3;
  logic [4:0] row1, row2, row3;
  logic [2:0] lo2;
  logic [7:0] prod;
  logic       fin_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= A;
      b_q <= B;
      v_q <= in_valid;
    end
  end

  assign pp0  = a_q & {4{b_q[0]}};
  assign pp1  = a_q & {4{b_q[1]}};
  assign pp2  = a_q & {4{b_q[2]}};
  assign row1 = row_add({1'b0, pp0[3:1]}, pp1);
  assign row2 = row_add(row1[4:1], pp2);
  assign lo2  = {row2[0], row1[0], pp0[0]};

`ifdef MULTI_4BIT_PIPE_EN
  logic [3:0] s_sum;
  logic [2:0] s_lo;
  logic [3:0] s_a;
  logic       s_b3;
  logic       s_v;

  // Mid-array stage: last row still needs the full multiplicand and B[3].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_sum <= '0;
      s_lo  <= '0;
      s_a   <= '0;
      s_b3  <= 1'b0;
      s_v   <= 1'b0;
    end else begin
      s_sum <= row2[4:1];
      s_lo  <= lo2;
      s_a   <= a_q;
      s_b3  <= b_q[3];
      s_v   <= v_q;
    end
  end

  assign pp3   = s_a & {4{s_b3}};
  assign row3  = row_add(s_sum, pp3);
  assign prod  = {row3, s_lo};
  assign fin_v = s_v;
`else
  assign pp3   = a_q & {4{b_q[3]}};
  assign row3  = row_add(row2[4:1], pp3);
  assign prod  = {row3, lo2};
  assign fin_v = v_q;
`endif

  // P only loads on a valid result so it holds the last product across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin_v;
      if (fin_v) P <= prod;
    end
  end

endmodule

// File: tb/tb_multi_4bit.sv
// Self-checking bench for multi_4bit: directed, corner, gap, reset, random and exhaustive streams
// against a cycle delay-line model of A*B.
module tb_multi_4bit;

`ifdef MULTI_4BIT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       in_valid = 1'b0;
  logic [7:0] P;
  logic       out_valid;

  multi_4bit dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .P(P), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference: pairs accepted at edge N emerge after edge N+LAT.
  logic       mv [0:LAT];
  logic [7:0] mp [0:LAT];
  logic       exp_v = 1'b0;
  logic [7:0] exp_p = 8'h00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
    checks++;
    assert (obs === exp_val) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_val);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v, input logic rn);
    @(negedge clk);
    A = a; B = b; in_valid = v; rst_n = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      for (int i = 0; i <= LAT; i++) begin mv[i] = 1'b0; mp[i] = 8'h00; end
      exp_v = 1'b0;
      exp_p = 8'h00;
    end else begin
      for (int i = LAT; i >= 1; i--) begin mv[i] = mv[i-1]; mp[i] = mp[i-1]; end
      mv[0] = v;
      mp[0] = 8'(a) * 8'(b);
      exp_v = mv[LAT];
      if (mv[LAT]) exp_p = mp[LAT];
    end
    if (out_valid === 1'b1) pulses++;
    check("out_valid", {7'd0, out_valid}, {7'd0, exp_v});
    check("P", P, exp_p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  logic [3:0] dir_a [10] = '{4'd3, 4'd9, 4'd11, 4'd2, 4'd10, 4'd8, 4'd15, 4'd0, 4'd1, 4'd15};
  logic [3:0] dir_b [10] = '{4'd2, 4'd3, 4'd3, 4'd7, 4'd10, 4'd6, 4'd15, 4'd13, 4'd15, 4'd1};
  logic [7:0] dir_p [10] = '{8'h06, 8'h1B, 8'h21, 8'h0E, 8'h64, 8'h30, 8'hE1, 8'h00, 8'h0F, 8'h0F};

  initial begin
    for (int i = 0; i <= LAT; i++) begin mv[i] = 1'b0; mp[i] = 8'h00; end

    // Reset with in_valid high: must be ignored.
    step(4'd5, 4'd5, 1'b1, 1'b0);
    step(4'd7, 4'd3, 1'b1, 1'b0);
    check("reset_P", P, 8'h00);

    // Directed pairs and corners back-to-back, then verify the emitted sequence.
    for (int i = 0; i < 10; i++) begin
      step(dir_a[i], dir_b[i], 1'b1, 1'b1);
      if (i >= LAT) check("directed_seq", P, dir_p[i-LAT]);
    end
    for (int i = 10 - LAT; i < 10; i++) begin
      step(4'd0, 4'd0, 1'b0, 1'b1);
      check("directed_tail", P, dir_p[i]);
    end
    idle(2);

    // Gap: one pulse, product held while idle.
    pulses = 0;
    step(4'd5, 4'd5, 1'b1, 1'b1);
    idle(3 + LAT);
    check("gap_pulses", 8'(pulses), 8'd1);
    check("gap_hold", P, 8'h19);

    // Reset mid-stream discards 7*7.
    pulses = 0;
    step(4'd7, 4'd7, 1'b1, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    check("rst_P", P, 8'h00);
    idle(4);
    check("rst_no_pulse", 8'(pulses), 8'd0);
    check("rst_no_31", {7'd0, P === 8'h31}, 8'd0);

    // Random traffic with random gaps.
    for (int i = 0; i < 200; i++)
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b1);
    idle(LAT + 1);

    // Exhaustive back-to-back stream.
    pulses = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(4'(a), 4'(b), 1'b1, 1'b1);
    idle(LAT + 2);
    check("exh_pulses_lo", 8'(pulses), 8'(256 & 8'hFF));
    check("exh_pulses_hi", 8'(pulses >> 8), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
